// File: rtl/registers_pkg.sv
// Shared defaults and scalar types for the registers_mp register file.
package registers_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int DEPTH_DEF     = 32;
   localparam int NUM_READ_DEF  = 2;
   localparam int NUM_WRITE_DEF = 1;
   localparam int ADDR_W_DEF    = $clog2(DEPTH_DEF);

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [XLEN_DEF-1:0]   reg_data_t;

endpackage

// File: rtl/registers_scoreboard.sv
// Busy scoreboard: one pending-reservation bit per register. A committed
// write clears the bit, an accepted reservation sets it, and set beats
// clear when both target the same register in one cycle. Bit 0 never sets.
module registers_scoreboard
   import registers_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEF,
   parameter int NUM_WRITE = NUM_WRITE_DEF,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_WRITE-1:0]              i_wr_en,
   input  logic [NUM_WRITE-1:0][ADDR_W-1:0]  i_wr_addr,
   input  logic [ADDR_W-1:0]                 i_rsv_addr,
   input  logic                              i_rsv_en,
   output logic [DEPTH-1:0]                  o_busy,
   output logic                              o_rsv_ok
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_clr;
   logic [DEPTH-1:0] w_busy_nxt;
   logic             w_rsv_hit;

   // Registers being written this cycle, and whether the reservation target is one of them
   always_comb begin
      w_clr     = '0;
      w_rsv_hit = 1'b0;
      for (int p = 0; p < NUM_WRITE; p++) begin
         if (i_wr_en[p]) begin
            w_clr[i_wr_addr[p]] = 1'b1;
            if (i_wr_addr[p] == i_rsv_addr) w_rsv_hit = 1'b1;
         end
      end
   end

   // A busy register can be re-reserved only if the write releasing it lands this cycle
   assign o_rsv_ok = i_rsv_en && !rst &&
                     ((i_rsv_addr == '0) || !r_busy[i_rsv_addr] || w_rsv_hit);

   // Next busy vector: clear on write, then set on accepted reservation (set wins)
   always_comb begin
      w_busy_nxt = r_busy & ~w_clr;
      if (o_rsv_ok) w_busy_nxt[i_rsv_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // Busy state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/registers_mp.sv
// registers_mp: multi-port register file. Register 0 is hardwired to zero,
// reads are combinational with optional same-cycle write forwarding, and a
// scoreboard tracks registers reserved by in-flight producers.
module registers_mp
   import registers_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int NUM_READ  = NUM_READ_DEF,
   parameter int NUM_WRITE = NUM_WRITE_DEF,
   parameter int BYPASS    = 0,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_READ-1:0][ADDR_W-1:0]   read_register,
   output logic [NUM_READ-1:0][XLEN-1:0]     result,
   output logic [NUM_READ-1:0]               result_busy,
   input  logic [NUM_WRITE-1:0][ADDR_W-1:0]  write_register,
   input  logic [NUM_WRITE-1:0][XLEN-1:0]    write_data,
   input  logic [NUM_WRITE-1:0]              write_data_valid,
   output logic [NUM_WRITE-1:0]              write_valid,
   input  logic [ADDR_W-1:0]                 reserve_register,
   input  logic                              reserve_en,
   output logic                              reserve_ok
);

   // Storage starts at index 1; register 0 has no flops and reads as zero.
   logic [XLEN-1:0]      r_mem [1:DEPTH-1];
   logic [NUM_WRITE-1:0] r_wr_ack;
   logic [DEPTH-1:0]     w_busy;

   // Commit writes; ascending port order lets the higher port win a collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         for (int p = 0; p < NUM_WRITE; p++) begin
            if (write_data_valid[p] && (write_register[p] != '0))
               r_mem[write_register[p]] <= write_data[p];
         end
      end
   end

   // Write acknowledge is the request delayed one cycle, register 0 included
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_wr_ack <= '0;
      else     r_wr_ack <= write_data_valid;
   end

   assign write_valid = r_wr_ack;

   // Per-port read mux with optional forwarding of this cycle's write data
   always_comb begin
      result = '0;
      for (int r = 0; r < NUM_READ; r++) begin
         if (read_register[r] != '0) begin
            result[r] = r_mem[read_register[r]];
            if ((BYPASS != 0) && !rst) begin
               for (int p = 0; p < NUM_WRITE; p++) begin
                  if (write_data_valid[p] && (write_register[p] == read_register[r]))
                     result[r] = write_data[p];
               end
            end
         end
      end
   end

   // Busy status per read port comes from the registered scoreboard only
   always_comb begin
      result_busy = '0;
      for (int r = 0; r < NUM_READ; r++) result_busy[r] = w_busy[read_register[r]];
   end

   registers_scoreboard #(
      .DEPTH     (DEPTH),
      .NUM_WRITE (NUM_WRITE)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (write_data_valid),
      .i_wr_addr  (write_register),
      .i_rsv_addr (reserve_register),
      .i_rsv_en   (reserve_en),
      .o_busy     (w_busy),
      .o_rsv_ok   (reserve_ok)
   );

endmodule

// File: tb/tb_registers_mp.sv
// Bench for registers_mp: one instance without forwarding and one with, both
// with two write ports, driven by identical stimulus and checked against a
// behavioural register/busy model plus a table of hand-derived vectors.
module tb_registers_mp;
   import registers_pkg::*;

   localparam int XL = 32;
   localparam int DP = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int AW = 5;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [NR-1:0][AW-1:0]  rd_addr;
   logic [NW-1:0][AW-1:0]  wr_addr;
   logic [NW-1:0][XL-1:0]  wr_data;
   logic [NW-1:0]          wr_v;
   logic [AW-1:0]          rsv_addr;
   logic                   rsv_en;

   logic [NR-1:0][XL-1:0]  res0, res1;
   logic [NR-1:0]          bsy0, bsy1;
   logic [NW-1:0]          wv0, wv1;
   logic                   ok0, ok1;

   int n_chk  = 0;
   int n_fail = 0;

   reg_data_t     m_mem  [DP];
   bit            m_busy [DP];
   logic [NW-1:0] m_wv;

   always #5 clk = ~clk;

   registers_mp #(.XLEN(XL), .DEPTH(DP), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) u_b0 (
      .clk(clk), .rst(rst), .read_register(rd_addr), .result(res0), .result_busy(bsy0),
      .write_register(wr_addr), .write_data(wr_data), .write_data_valid(wr_v),
      .write_valid(wv0), .reserve_register(rsv_addr), .reserve_en(rsv_en), .reserve_ok(ok0));

   registers_mp #(.XLEN(XL), .DEPTH(DP), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) u_b1 (
      .clk(clk), .rst(rst), .read_register(rd_addr), .result(res1), .result_busy(bsy1),
      .write_register(wr_addr), .write_data(wr_data), .write_data_valid(wr_v),
      .write_valid(wv1), .reserve_register(rsv_addr), .reserve_en(rsv_en), .reserve_ok(ok1));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] m_read(input int a, input bit byp);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      v = m_mem[a];
      if (byp && !rst)
         for (int p = 0; p < NW; p++)
            if (wr_v[p] && int'(wr_addr[p]) == a) v = wr_data[p];
      return v;
   endfunction

   function automatic bit m_ok();
      int a;
      bit hit;
      a   = int'(rsv_addr);
      hit = 1'b0;
      if (!rsv_en || rst) return 1'b0;
      for (int p = 0; p < NW; p++)
         if (wr_v[p] && int'(wr_addr[p]) == a) hit = 1'b1;
      return (a == 0) || !m_busy[a] || hit;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < DP; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_wv = '0;
   endtask

   task automatic m_edge();
      bit ok;
      ok = m_ok();
      if (rst) begin
         m_clear();
         return;
      end
      for (int p = 0; p < NW; p++) begin
         if (wr_v[p]) begin
            if (wr_addr[p] != '0) m_mem[wr_addr[p]] = wr_data[p];
            m_busy[wr_addr[p]] = 1'b0;
         end
      end
      if (ok && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
      m_wv = wr_v;
   endtask

   task automatic check_model();
      for (int r = 0; r < NR; r++) begin
         chk($sformatf("b0_result%0d", r), res0[r], m_read(int'(rd_addr[r]), 1'b0));
         chk($sformatf("b1_result%0d", r), res1[r], m_read(int'(rd_addr[r]), 1'b1));
         chk($sformatf("b0_busy%0d", r), 32'(bsy0[r]), 32'(m_busy[rd_addr[r]]));
         chk($sformatf("b1_busy%0d", r), 32'(bsy1[r]), 32'(m_busy[rd_addr[r]]));
      end
      chk("b0_write_valid", 32'(wv0), 32'(m_wv));
      chk("b1_write_valid", 32'(wv1), 32'(m_wv));
      chk("b0_reserve_ok", 32'(ok0), 32'(m_ok()));
      chk("b1_reserve_ok", 32'(ok1), 32'(m_ok()));
   endtask

   task automatic tick();
      @(negedge clk); #2;
      check_model();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic idle();
      wr_v    = '0;
      wr_addr = '0;
      wr_data = '0;
      rsv_en  = 1'b0;
      rsv_addr = '0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [AW-1:0] ra0;
      logic          wv0;  logic [AW-1:0] wa0;  logic [31:0] wd0;
      logic          wv1;  logic [AW-1:0] wa1;  logic [31:0] wd1;
      logic          re;   logic [AW-1:0] rr;
      logic [31:0]   e_r_b0, e_r_b1;
      logic          e_busy;
      logic [1:0]    e_wv;
      logic          e_ok;
   } vec_t;

   function automatic vec_t mk(input logic [AW-1:0] ra0,
      input logic wv0, input logic [AW-1:0] wa0, input logic [31:0] wd0,
      input logic wv1, input logic [AW-1:0] wa1, input logic [31:0] wd1,
      input logic re, input logic [AW-1:0] rr,
      input logic [31:0] e0, input logic [31:0] e1, input logic eb,
      input logic [1:0] ewv, input logic eok);
      vec_t v;
      v.ra0 = ra0; v.wv0 = wv0; v.wa0 = wa0; v.wd0 = wd0;
      v.wv1 = wv1; v.wa1 = wa1; v.wd1 = wd1; v.re = re; v.rr = rr;
      v.e_r_b0 = e0; v.e_r_b1 = e1; v.e_busy = eb; v.e_wv = ewv; v.e_ok = eok;
      return v;
   endfunction

   vec_t vt [18];

   initial begin
      // Expected values are what each output shows before the row's clock edge.
      vt[0]  = mk(0, 0,0,0,            0,0,0,            0,0, 32'h0,         32'h0,         0, 2'b00, 0);
      vt[1]  = mk(0, 1,0,32'hFFFF_FFFF, 0,0,0,           0,0, 32'h0,         32'h0,         0, 2'b00, 0);
      vt[2]  = mk(0, 0,0,0,            0,0,0,            0,0, 32'h0,         32'h0,         0, 2'b01, 0);
      vt[3]  = mk(1, 1,1,32'hDEAD_BEEF, 0,0,0,           0,0, 32'h0,         32'hDEAD_BEEF, 0, 2'b00, 0);
      vt[4]  = mk(1, 0,1,32'hAABB_CCDD, 0,0,0,           0,0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 2'b01, 0);
      vt[5]  = mk(1, 0,0,0,            0,0,0,            0,0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 2'b00, 0);
      vt[6]  = mk(5, 1,5,32'h1234_5678, 0,0,0,           0,0, 32'h0,         32'h1234_5678, 0, 2'b00, 0);
      vt[7]  = mk(5, 0,0,0,            0,0,0,            0,0, 32'h1234_5678, 32'h1234_5678, 0, 2'b01, 0);
      vt[8]  = mk(3, 0,0,0,            0,0,0,            1,3, 32'h0,         32'h0,         0, 2'b00, 1);
      vt[9]  = mk(3, 0,0,0,            0,0,0,            1,3, 32'h0,         32'h0,         1, 2'b00, 0);
      vt[10] = mk(3, 1,3,32'hCAFE_0003, 0,0,0,           1,3, 32'h0,         32'hCAFE_0003, 1, 2'b00, 1);
      vt[11] = mk(3, 0,0,0,            0,0,0,            0,0, 32'hCAFE_0003, 32'hCAFE_0003, 1, 2'b01, 0);
      vt[12] = mk(7, 1,7,32'h1111_1111, 1,7,32'h2222_2222, 0,0, 32'h0,       32'h2222_2222, 0, 2'b00, 0);
      vt[13] = mk(7, 0,0,0,            0,0,0,            0,0, 32'h2222_2222, 32'h2222_2222, 0, 2'b11, 0);
      vt[14] = mk(3, 1,3,32'h0,        0,0,0,            0,0, 32'hCAFE_0003, 32'h0,         1, 2'b00, 0);
      vt[15] = mk(3, 0,0,0,            0,0,0,            0,0, 32'h0,         32'h0,         0, 2'b01, 0);
      vt[16] = mk(0, 0,0,0,            0,0,0,            1,0, 32'h0,         32'h0,         0, 2'b00, 1);
      vt[17] = mk(0, 0,0,0,            0,0,0,            0,0, 32'h0,         32'h0,         0, 2'b00, 0);

      idle();
      rd_addr = '0;
      m_clear();

      // Reset: hold for two cycles with checks while asserted
      #1 rst = 1'b1;
      m_clear();
      tick();
      tick();
      rst = 1'b0;

      // Table-driven directed vectors
      for (int i = 0; i < 18; i++) begin
         rd_addr[0] = vt[i].ra0;
         rd_addr[1] = 5'd1;
         wr_v       = {vt[i].wv1, vt[i].wv0};
         wr_addr[0] = vt[i].wa0;  wr_data[0] = vt[i].wd0;
         wr_addr[1] = vt[i].wa1;  wr_data[1] = vt[i].wd1;
         rsv_en     = vt[i].re;
         rsv_addr   = vt[i].rr;
         @(negedge clk); #2;
         chk($sformatf("vec%0d_b0_result", i), res0[0], vt[i].e_r_b0);
         chk($sformatf("vec%0d_b1_result", i), res1[0], vt[i].e_r_b1);
         chk($sformatf("vec%0d_busy", i), 32'(bsy0[0]), 32'(vt[i].e_busy));
         chk($sformatf("vec%0d_write_valid", i), 32'(wv0), 32'(vt[i].e_wv));
         chk($sformatf("vec%0d_reserve_ok", i), 32'(ok1), 32'(vt[i].e_ok));
         check_model();
         @(posedge clk);
         m_edge();
         #1;
      end

      // Mid-cycle asynchronous reset with state loaded and a write in flight
      idle();
      rd_addr[0] = 5'd9;  rd_addr[1] = 5'd10;
      wr_v = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h0000_0099;
      rsv_en = 1'b1; rsv_addr = 5'd10;
      tick();
      idle();
      wr_v = 2'b01; wr_addr[0] = 5'd11; wr_data[0] = 32'hBBBB_0011;
      rsv_en = 1'b1; rsv_addr = 5'd12;
      @(negedge clk); #2;
      check_model();
      chk("pre_rst_r9", res0[0], 32'h0000_0099);
      chk("pre_rst_busy10", 32'(bsy0[1]), 32'h1);
      rst = 1'b1;
      m_clear();
      #1;
      check_model();
      chk("rst_async_r9_b0", res0[0], 32'h0);
      chk("rst_async_r9_b1", res1[0], 32'h0);
      chk("rst_async_busy10", 32'(bsy0[1]), 32'h0);
      chk("rst_reserve_ok", 32'(ok0), 32'h0);
      @(posedge clk);
      m_edge();
      #1;
      tick();
      rst = 1'b0;
      rd_addr[0] = 5'd11; rd_addr[1] = 5'd12;
      @(negedge clk); #2;
      check_model();
      chk("post_rst_r11_b0", res0[0], 32'h0);
      chk("post_rst_busy12", 32'(bsy0[1]), 32'h0);
      chk("post_rst_reserve_ok", 32'(ok0), 32'h1);
      @(posedge clk);
      m_edge();
      #1;
      idle();
      @(negedge clk); #2;
      chk("first_edge_write_r11", res0[0], 32'hBBBB_0011);
      chk("first_edge_reserve12", 32'(bsy0[1]), 32'h1);
      chk("first_edge_write_valid", 32'(wv0), 32'h1);
      @(posedge clk);
      m_edge();
      #1;

      // Randomized traffic over a small address window to force collisions
      for (int c = 0; c < 800; c++) begin
         for (int r = 0; r < NR; r++) rd_addr[r] = AW'($urandom_range(0, 7));
         for (int p = 0; p < NW; p++) begin
            wr_v[p]    = 1'($urandom_range(0, 1));
            wr_addr[p] = AW'($urandom_range(0, 7));
            wr_data[p] = $urandom;
         end
         rsv_en   = 1'($urandom_range(0, 1));
         rsv_addr = AW'($urandom_range(0, 7));
         if (!rst && $urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            m_clear();
         end else begin
            rst = 1'b0;
         end
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
